// File: rtl/mcpu_run_ctrl_pkg.sv
// Shared encodings for the mcpu run controller: FSM states, stop causes, core reset levels.
// The cause helper fixes the stop priority in one place: abort over halt over timeout.
package mcpu_run_ctrl_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  typedef enum logic [1:0] {
    RUNC_IDLE  = 2'd0,
    RUNC_RESET = 2'd1,
    RUNC_RUN   = 2'd2,
    RUNC_DONE  = 2'd3
  } runc_state_e;

  typedef enum logic [1:0] {
    RUNC_NONE    = 2'b00,
    RUNC_TIMEOUT = 2'b01,
    RUNC_HALT    = 2'b10,
    RUNC_ABORT   = 2'b11
  } runc_cause_e;

  function automatic runc_cause_e runc_stop_cause(input logic abort_hit, input logic halt_hit);
    if (abort_hit) return RUNC_ABORT;
    if (halt_hit)  return RUNC_HALT;
    return RUNC_TIMEOUT;
  endfunction

endpackage

// File: rtl/mcpu_trace_buf.sv
// Circular trace of decode-stage PC/instruction pairs; a pair is kept on the first run cycle
// and whenever the PC moves. Oldest entries are overwritten once full; reads are combinational.
module mcpu_trace_buf
  import mcpu_run_ctrl_pkg::*;
#(
  parameter int unsigned  PC_W        = 16,
  parameter int unsigned  INST_W      = 16,
  parameter int unsigned  TRACE_DEPTH = 16,
  localparam int unsigned AW          = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic              first_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [AW-1:0]     rd_idx_i,
  output logic [AW:0]       trace_cnt_o,
  output logic [PC_W-1:0]   rd_pc_o,
  output logic [INST_W-1:0] rd_inst_o
);

  logic [PC_W+INST_W-1:0] mem_q [TRACE_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic [PC_W-1:0]        last_pc_q, last_pc_d;
  logic                   cap;
  logic [AW-1:0]          rd_phys;
  logic                   rd_vld;
  logic [PC_W+INST_W-1:0] rd_ent;

  assign cap = wr_en_i && !rst && (first_i || (pc_i != last_pc_q));

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    last_pc_d = last_pc_q;
    if (clr_i) begin
      wr_ptr_d  = '0;
      cnt_d     = '0;
      last_pc_d = '0;
    end else if (cap) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      last_pc_d = pc_i;
      // depth is a power of two, so the top bit alone means full
      if (!cnt_q[AW]) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      last_pc_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      last_pc_q <= last_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) mem_q[wr_ptr_q] <= {pc_i, inst_i};
  end

  // once wrapped, wr_ptr already points at the oldest surviving entry
  assign rd_phys = cnt_q[AW] ? (wr_ptr_q + rd_idx_i) : rd_idx_i;
  assign rd_vld  = ({1'b0, rd_idx_i} < cnt_q);
  assign rd_ent  = rd_vld ? mem_q[rd_phys] : '0;

  assign trace_cnt_o = cnt_q;
  assign rd_pc_o     = rd_ent[PC_W+INST_W-1:INST_W];
  assign rd_inst_o   = rd_ent[INST_W-1:0];

endmodule

// File: rtl/mcpu_run_ctrl.sv
// Run controller for the mcpu core: holds core reset, runs, stops on abort/halt/timeout, reports cause.
// Trace buffer is built only when MCPU_RUN_TRACE_EN is defined; otherwise trace outputs read 0.
module mcpu_run_ctrl
  import mcpu_run_ctrl_pkg::*;
#(
  parameter int unsigned       PC_W        = 16,
  parameter int unsigned       INST_W      = 16,
  parameter int unsigned       RST_CYCLES  = 3,
  parameter int unsigned       RUN_CYCLES  = 100,
  parameter logic [INST_W-1:0] HALT_INST   = 16'hFFFF,
  parameter int unsigned       TRACE_DEPTH = 16,
  localparam int unsigned      AW          = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PC_W-1:0]   id_pc_i,
  input  logic [INST_W-1:0] id_inst_i,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [1:0]        done_cause,
  output logic [31:0]       cycle_cnt,
  output logic [AW:0]       trace_cnt,
  input  logic [AW-1:0]     rd_idx,
  output logic [PC_W-1:0]   rd_pc,
  output logic [INST_W-1:0] rd_inst
);

  runc_state_e state_q, state_d;
  runc_cause_e cause_q, cause_d;
  logic [31:0] rst_cnt_q, rst_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        start_acc, in_run, halt_hit, timeout_hit, stop_run;

  assign start_acc   = start && ((state_q == RUNC_IDLE) || (state_q == RUNC_DONE));
  assign in_run      = (state_q == RUNC_RUN);
  assign halt_hit    = (id_inst_i == HALT_INST);
  assign timeout_hit = (cycle_cnt_q == 32'(RUN_CYCLES - 1));
  assign stop_run    = abort || halt_hit || timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUNC_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUNC_IDLE, RUNC_DONE: if (start) state_d = RUNC_RESET;
      RUNC_RESET: begin
        if (abort)                 state_d = RUNC_DONE;
        else if (rst_cnt_q == '0)  state_d = RUNC_RUN;
      end
      RUNC_RUN: if (stop_run) state_d = RUNC_DONE;
      default: state_d = RUNC_IDLE;
    endcase
  end

  always_comb begin
    cpu_rst = RstEnable;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      RUNC_RESET: busy = 1'b1;
      RUNC_RUN: begin
        busy    = 1'b1;
        cpu_rst = RstDisable;
      end
      RUNC_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // the stopping cycle is itself counted, so a timeout lands on exactly RUN_CYCLES
  always_comb begin
    rst_cnt_d   = rst_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    cause_d     = cause_q;
    if (start_acc) begin
      rst_cnt_d   = 32'(RST_CYCLES - 1);
      cycle_cnt_d = '0;
      cause_d     = RUNC_NONE;
    end else if (state_q == RUNC_RESET) begin
      if (abort)                 cause_d   = RUNC_ABORT;
      else if (rst_cnt_q != '0)  rst_cnt_d = rst_cnt_q - 1'b1;
    end else if (in_run) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
      if (stop_run) cause_d = runc_stop_cause(abort, halt_hit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      cause_q     <= RUNC_NONE;
    end else begin
      rst_cnt_q   <= rst_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      cause_q     <= cause_d;
    end
  end

  assign done_cause = cause_q;
  assign cycle_cnt  = cycle_cnt_q;

`ifdef MCPU_RUN_TRACE_EN
  mcpu_trace_buf #(
    .PC_W        (PC_W),
    .INST_W      (INST_W),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace_buf (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (start_acc),
    .wr_en_i     (in_run),
    .first_i     (cycle_cnt_q == '0),
    .pc_i        (id_pc_i),
    .inst_i      (id_inst_i),
    .rd_idx_i    (rd_idx),
    .trace_cnt_o (trace_cnt),
    .rd_pc_o     (rd_pc),
    .rd_inst_o   (rd_inst)
  );
`else
  logic unused_trace;
  assign unused_trace = ^{rd_idx, id_pc_i};
  assign trace_cnt    = '0;
  assign rd_pc        = '0;
  assign rd_inst      = '0;
`endif

endmodule

// File: tb/tb_mcpu_run_ctrl.sv
// Self-checking bench for mcpu_run_ctrl: directed and randomized runs scored against a
// run-level model (stop point by priority rules, trace as a bounded queue of PC changes).
module tb_mcpu_run_ctrl;

  localparam int PC_W        = 16;
  localparam int INST_W      = 16;
  localparam int RST_CYCLES  = 3;
  localparam int RUN_CYCLES  = 100;
  localparam int TRACE_DEPTH = 16;
  localparam int AW          = 4;
  localparam int MAXC        = RUN_CYCLES + 4;
  localparam logic [15:0] HALT = 16'hFFFF;
`ifdef MCPU_RUN_TRACE_EN
  localparam bit TRACE_EN = 1'b1;
`else
  localparam bit TRACE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [PC_W-1:0]   id_pc_i = '0;
  logic [INST_W-1:0] id_inst_i = '0;
  logic              cpu_rst, busy, done;
  logic [1:0]        done_cause;
  logic [31:0]       cycle_cnt;
  logic [AW:0]       trace_cnt;
  logic [AW-1:0]     rd_idx = '0;
  logic [PC_W-1:0]   rd_pc;
  logic [INST_W-1:0] rd_inst;

  int vec = 0;
  int miscmp = 0;

  logic [15:0] pc_a   [0:MAXC];
  logic [15:0] inst_a [0:MAXC];
  bit          abort_a[0:MAXC];
  bit          start_a[0:MAXC];

  mcpu_run_ctrl #(
    .PC_W(PC_W), .INST_W(INST_W), .RST_CYCLES(RST_CYCLES), .RUN_CYCLES(RUN_CYCLES),
    .HALT_INST(HALT), .TRACE_DEPTH(TRACE_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .id_pc_i(id_pc_i), .id_inst_i(id_inst_i),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .done_cause(done_cause), .cycle_cnt(cycle_cnt),
    .trace_cnt(trace_cnt), .rd_idx(rd_idx), .rd_pc(rd_pc), .rd_inst(rd_inst)
  );

  always #5 clk = ~clk;

  task automatic clear_stim();
    for (int k = 0; k <= MAXC; k++) begin
      pc_a[k] = '0; inst_a[k] = '0; abort_a[k] = 1'b0; start_a[k] = 1'b0;
    end
  endtask

  // Starts a run from IDLE/DONE using the stimulus arrays and scores it end to end.
  task automatic run_case(input string name, input bit abort_in_reset);
    logic [31:0] q[$];
    logic [15:0] last_pc;
    logic [1:0]  ecause;
    int          k_end;
    int          ecnt;
    k_end = 0; ecause = 2'b00; last_pc = '0;
    if (abort_in_reset) ecause = 2'b11;
    else begin
      for (int k = 1; k <= RUN_CYCLES && k_end == 0; k++) begin
        if (abort_a[k])               begin k_end = k; ecause = 2'b11; end
        else if (inst_a[k] == HALT)   begin k_end = k; ecause = 2'b10; end
        else if (k == RUN_CYCLES)     begin k_end = k; ecause = 2'b01; end
      end
    end
    for (int k = 1; k <= k_end; k++) begin
      if (k == 1 || pc_a[k] != last_pc) begin
        q.push_back({pc_a[k], inst_a[k]});
        last_pc = pc_a[k];
        if (q.size() > TRACE_DEPTH) void'(q.pop_front());
      end
    end
    ecnt = TRACE_EN ? q.size() : 0;

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vec++;
    if (busy !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1 || cycle_cnt !== 32'd0 ||
        done_cause !== 2'b00 || trace_cnt !== '0)
      begin miscmp++; $display("FAIL %s start: busy=%0b done=%0b cpu_rst=%0b cnt=%0d cause=%0d tcnt=%0d, want 1 0 1 0 0 0",
        name, busy, done, cpu_rst, cycle_cnt, done_cause, trace_cnt); end

    if (abort_in_reset) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end else begin
      for (int r = 1; r < RST_CYCLES; r++) begin
        @(posedge clk); #1;
        vec++;
        if (cpu_rst !== 1'b1 || busy !== 1'b1)
          begin miscmp++; $display("FAIL %s rst_hold r=%0d: cpu_rst=%0b busy=%0b, want 1 1", name, r, cpu_rst, busy); end
      end
      @(posedge clk); #1;
      vec++;
      if (cpu_rst !== 1'b0 || busy !== 1'b1)
        begin miscmp++; $display("FAIL %s release: cpu_rst=%0b busy=%0b, want 0 1", name, cpu_rst, busy); end
      for (int k = 1; k <= k_end + 2; k++) begin
        if (k <= k_end) begin
          id_pc_i = pc_a[k]; id_inst_i = inst_a[k]; abort = abort_a[k]; start = start_a[k];
        end else begin
          id_pc_i = 16'($urandom); id_inst_i = 16'($urandom); abort = 1'($urandom_range(0, 1)); start = 1'b0;
        end
        @(posedge clk); #1;
        vec++;
        if (k < k_end) begin
          if (done !== 1'b0 || cpu_rst !== 1'b0 || cycle_cnt !== 32'(k))
            begin miscmp++; $display("FAIL %s run k=%0d: done=%0b cpu_rst=%0b cnt=%0d, want 0 0 %0d", name, k, done, cpu_rst, cycle_cnt, k); end
        end else if (done !== 1'b1 || busy !== 1'b0 || cpu_rst !== 1'b1 || cycle_cnt !== 32'(k_end) || done_cause !== ecause)
          begin miscmp++; $display("FAIL %s stop k=%0d: done=%0b busy=%0b cpu_rst=%0b cnt=%0d cause=%0d, want 1 0 1 %0d %0d",
            name, k, done, busy, cpu_rst, cycle_cnt, done_cause, k_end, ecause); end
      end
      abort = 1'b0; start = 1'b0; id_pc_i = '0; id_inst_i = '0;
    end

    vec++;
    if (done !== 1'b1 || done_cause !== ecause || cycle_cnt !== 32'(k_end) || trace_cnt !== 5'(ecnt))
      begin miscmp++; $display("FAIL %s final: done=%0b cause=%0d cnt=%0d tcnt=%0d, want 1 %0d %0d %0d",
        name, done, done_cause, cycle_cnt, trace_cnt, ecause, k_end, ecnt); end

    for (int i = 0; i < TRACE_DEPTH; i++) begin
      logic [31:0] exp_e;
      exp_e = (TRACE_EN && i < q.size()) ? q[i] : 32'h0;
      @(negedge clk);
      rd_idx = 4'(i);
      #1;
      vec++;
      if ({rd_pc, rd_inst} !== exp_e)
        begin miscmp++; $display("FAIL %s read idx=%0d: pc=%h inst=%h, want pc=%h inst=%h",
          name, i, rd_pc, rd_inst, exp_e[31:16], exp_e[15:0]); end
    end
    rd_idx = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (cpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      begin miscmp++; $display("FAIL reset ctl: cpu_rst=%0b busy=%0b done=%0b, want 1 0 0", cpu_rst, busy, done); end
    vec++;
    if (done_cause !== 2'b00 || cycle_cnt !== 32'd0 || trace_cnt !== '0)
      begin miscmp++; $display("FAIL reset cnt: cause=%0d cnt=%0d tcnt=%0d, want 0 0 0", done_cause, cycle_cnt, trace_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    clear_stim();
    for (int k = 1; k <= MAXC; k++) begin
      pc_a[k] = 16'(k); inst_a[k] = 16'($urandom_range(0, 16'hFFFE));
    end
    run_case("timeout", 1'b0);
  endtask

  task automatic test_halt();
    clear_stim();
    for (int k = 1; k <= 4; k++) begin
      pc_a[k] = 16'(k - 1); inst_a[k] = 16'($urandom_range(0, 16'hFFFE));
    end
    pc_a[5] = 16'd3; inst_a[5] = HALT;
    run_case("halt", 1'b0);
  endtask

  task automatic test_wrap();
    clear_stim();
    for (int k = 1; k <= 20; k++) begin
      pc_a[k] = 16'(k - 1); inst_a[k] = 16'($urandom_range(0, 16'hFFFE));
    end
    inst_a[20] = HALT;
    run_case("wrap", 1'b0);
  endtask

  task automatic test_abort();
    clear_stim();
    run_case("abort_reset", 1'b1);
    clear_stim();
    for (int k = 1; k <= 10; k++) begin
      pc_a[k] = 16'($urandom); inst_a[k] = 16'($urandom_range(0, 16'hFFFE));
    end
    inst_a[7] = HALT; abort_a[7] = 1'b1;
    run_case("abort_on_halt", 1'b0);
  endtask

  task automatic test_halt_on_timeout();
    clear_stim();
    for (int k = 1; k <= MAXC; k++) begin
      pc_a[k] = 16'(k * 2); inst_a[k] = 16'($urandom_range(0, 16'hFFFE));
    end
    inst_a[RUN_CYCLES] = HALT;
    start_a[10] = 1'b1; start_a[50] = 1'b1;
    run_case("halt_on_timeout", 1'b0);
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      logic [15:0] pc;
      clear_stim();
      pc = 16'($urandom);
      for (int k = 1; k <= MAXC; k++) begin
        if ($urandom_range(0, 2) != 0) pc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
        pc_a[k]    = pc;
        inst_a[k]  = ($urandom_range(0, 39) == 0) ? HALT : 16'($urandom_range(0, 16'hFFFE));
        abort_a[k] = ($urandom_range(0, 79) == 0);
        start_a[k] = ($urandom_range(0, 19) == 0);
      end
      run_case($sformatf("random%0d", t), 1'b0);
    end
  endtask

  task automatic test_rst_mid_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (RST_CYCLES) @(posedge clk);
    #1;
    for (int k = 1; k <= 10; k++) begin
      id_pc_i = 16'(k + 100); id_inst_i = 16'h1234;
      @(posedge clk); #1;
    end
    vec++;
    if (busy !== 1'b1 || cpu_rst !== 1'b0 || cycle_cnt !== 32'd10)
      begin miscmp++; $display("FAIL mid_run pre: busy=%0b cpu_rst=%0b cnt=%0d, want 1 0 10", busy, cpu_rst, cycle_cnt); end
    rst = 1'b1;
    @(posedge clk); #1;
    vec++;
    if (cpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || done_cause !== 2'b00 ||
        cycle_cnt !== 32'd0 || trace_cnt !== '0 || rd_pc !== '0 || rd_inst !== '0)
      begin miscmp++; $display("FAIL mid_run rst: cpu_rst=%0b busy=%0b done=%0b cause=%0d cnt=%0d tcnt=%0d pc=%h inst=%h, want 1 0 0 0 0 0 0 0",
        cpu_rst, busy, done, done_cause, cycle_cnt, trace_cnt, rd_pc, rd_inst); end
    rst = 1'b0;
    id_pc_i = '0; id_inst_i = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_halt();
    test_wrap();
    test_abort();
    test_halt_on_timeout();
    test_random(6);
    test_rst_mid_run();
    test_halt();
    test_random(2);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
